// File: rtl/door_sec_pkg.sv
// Shared door-security datapath definitions: command encodings and digit width.
package door_sec_pkg;

  localparam int unsigned DEF_DIGIT_W = 4;
  localparam int unsigned CMD_W       = 3;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP       = 3'd0,
    CMD_LOAD_A    = 3'd1,
    CMD_LOAD_B    = 3'd2,
    CMD_SHIFT_IN  = 3'd3,
    CMD_BACKSPACE = 3'd4,
    CMD_CLEAR     = 3'd5
  } cmd_e;

endpackage

// File: rtl/digit_entry_register.sv
// Multi-digit keypad entry register: whole loads, shift-in, backspace, clear,
// digit count tracking and rejection pulse for illegal commands.
module digit_entry_register
  import door_sec_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned DIGIT_W   = DEF_DIGIT_W,
  parameter int unsigned MAX_DIGIT = 9
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cmd_valid,
  input  logic [2:0]                       cmd,
  input  logic [DIGIT_W-1:0]               key_digit,
  input  logic [DIGITS*DIGIT_W-1:0]        src_a,
  input  logic [DIGITS*DIGIT_W-1:0]        src_b,
  output logic [DIGITS*DIGIT_W-1:0]        result,
  output logic [$clog2(DIGITS+1)-1:0]      count,
  output logic                             empty,
  output logic                             full,
  output logic                             err
);

  localparam int unsigned BUS_W = DIGITS * DIGIT_W;
  localparam int unsigned CNT_W = $clog2(DIGITS + 1);
  localparam logic [DIGIT_W-1:0] MAX_KEY  = DIGIT_W'(MAX_DIGIT);
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(DIGITS);

  cmd_e             cmd_sel;
  logic             cmd_ok;
  logic [BUS_W-1:0] shift_val;
  logic [BUS_W-1:0] bksp_val;
  logic [BUS_W-1:0] result_nxt;
  logic [CNT_W-1:0] count_nxt;

  assign cmd_sel = cmd_e'(cmd);

  // Shift network: shift-in moves digits up with the key entering at digit 0,
  // backspace moves digits down with zero entering at the top.
  for (genvar i = 0; i < DIGITS; i++) begin : g_shift
    if (i == 0) begin : g_low
      assign shift_val[DIGIT_W-1:0] = key_digit;
    end else begin : g_up
      assign shift_val[i*DIGIT_W +: DIGIT_W] = result[(i-1)*DIGIT_W +: DIGIT_W];
    end
    if (i == DIGITS - 1) begin : g_top
      assign bksp_val[i*DIGIT_W +: DIGIT_W] = '0;
    end else begin : g_down
      assign bksp_val[i*DIGIT_W +: DIGIT_W] = result[(i+1)*DIGIT_W +: DIGIT_W];
    end
  end

  // Accept/reject decision shared by the datapath enable and the err register.
  always_comb begin
    cmd_ok = 1'b0;
    case (cmd_sel)
      CMD_NOP, CMD_LOAD_A, CMD_LOAD_B, CMD_CLEAR: cmd_ok = 1'b1;
      CMD_SHIFT_IN:  cmd_ok = !full && (key_digit <= MAX_KEY);
      CMD_BACKSPACE: cmd_ok = !empty;
      default:       cmd_ok = 1'b0;
    endcase
  end

  // Next digits and count for an accepted valid command; hold otherwise.
  always_comb begin
    result_nxt = result;
    count_nxt  = count;
    if (cmd_valid && cmd_ok) begin
      case (cmd_sel)
        CMD_LOAD_A: begin
          result_nxt = src_a;
          count_nxt  = CNT_FULL;
        end
        CMD_LOAD_B: begin
          result_nxt = src_b;
          count_nxt  = CNT_FULL;
        end
        CMD_SHIFT_IN: begin
          result_nxt = shift_val;
          count_nxt  = count + CNT_W'(1);
        end
        CMD_BACKSPACE: begin
          result_nxt = bksp_val;
          count_nxt  = count - CNT_W'(1);
        end
        CMD_CLEAR: begin
          result_nxt = '0;
          count_nxt  = '0;
        end
        default: begin
          result_nxt = result;
          count_nxt  = count;
        end
      endcase
    end
  end

  // State and flag registers; flags derive from the next count so they track it.
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      err    <= 1'b0;
    end else begin
      result <= result_nxt;
      count  <= count_nxt;
      empty  <= (count_nxt == '0);
      full   <= (count_nxt == CNT_FULL);
      err    <= cmd_valid && !cmd_ok;
    end
  end

endmodule

// File: tb/tb_digit_entry_register.sv
// Self-checking bench for digit_entry_register at DIGITS=4 and DIGITS=6,
// using a queue-of-entered-digits reference model.
module tb_digit_entry_register;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance with default parameters
  logic        rst4, v4;
  logic [2:0]  cmd4;
  logic [3:0]  key4;
  logic [15:0] a4, b4, res4;
  logic [2:0]  cnt4;
  logic        empty4, full4, err4;

  // Instance with six digits
  logic        rst6, v6;
  logic [2:0]  cmd6;
  logic [3:0]  key6;
  logic [23:0] a6, b6, res6;
  logic [2:0]  cnt6;
  logic        empty6, full6, err6;

  digit_entry_register #(.DIGITS(4), .DIGIT_W(4), .MAX_DIGIT(9)) dut4 (
    .clk(clk), .reset(rst4), .cmd_valid(v4), .cmd(cmd4), .key_digit(key4),
    .src_a(a4), .src_b(b4), .result(res4), .count(cnt4),
    .empty(empty4), .full(full4), .err(err4)
  );

  digit_entry_register #(.DIGITS(6), .DIGIT_W(4), .MAX_DIGIT(9)) dut6 (
    .clk(clk), .reset(rst6), .cmd_valid(v6), .cmd(cmd6), .key_digit(key6),
    .src_a(a6), .src_b(b6), .result(res6), .count(cnt6),
    .empty(empty6), .full(full6), .err(err6)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: entered digits, index 0 = most recent
  int m_q[2][$];
  bit m_err[2];

  function automatic void model_update(input int k, input int nd, input bit r,
                                       input bit v, input int c, input int key,
                                       input logic [23:0] a, input logic [23:0] b);
    logic [23:0] src;
    m_err[k] = 1'b0;
    if (r) begin
      m_q[k].delete();
      return;
    end
    if (!v) return;
    case (c)
      0: ;
      1, 2: begin
        src = (c == 1) ? a : b;
        m_q[k].delete();
        for (int i = 0; i < nd; i++) m_q[k].push_back(int'((src >> (4 * i)) & 24'hF));
      end
      3: begin
        if (m_q[k].size() == nd || key > 9) m_err[k] = 1'b1;
        else m_q[k].push_front(key);
      end
      4: begin
        if (m_q[k].size() == 0) m_err[k] = 1'b1;
        else void'(m_q[k].pop_front());
      end
      5: m_q[k].delete();
      default: m_err[k] = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model_result(input int k);
    logic [31:0] r = '0;
    for (int i = 0; i < m_q[k].size(); i++) r |= 32'(m_q[k][i]) << (4 * i);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("res4",   32'(res4),   model_result(0));
    chk("cnt4",   32'(cnt4),   32'(m_q[0].size()));
    chk("empty4", 32'(empty4), 32'(m_q[0].size() == 0));
    chk("full4",  32'(full4),  32'(m_q[0].size() == 4));
    chk("err4",   32'(err4),   32'(m_err[0]));
    chk("res6",   32'(res6),   model_result(1));
    chk("cnt6",   32'(cnt6),   32'(m_q[1].size()));
    chk("empty6", 32'(empty6), 32'(m_q[1].size() == 0));
    chk("full6",  32'(full6),  32'(m_q[1].size() == 6));
    chk("err6",   32'(err6),   32'(m_err[1]));
  endtask

  // k: 0 = drive 4-digit instance, 1 = 6-digit instance, 2 = both
  task automatic step(input int k, input bit r, input bit v, input int c,
                      input int key, input logic [23:0] a, input logic [23:0] b);
    rst4 = 1'b0; v4 = 1'b0; cmd4 = 3'(c); key4 = 4'(key); a4 = a[15:0]; b4 = b[15:0];
    rst6 = 1'b0; v6 = 1'b0; cmd6 = 3'(c); key6 = 4'(key); a6 = a;       b6 = b;
    if (k == 0 || k == 2) begin rst4 = r; v4 = v; end
    if (k == 1 || k == 2) begin rst6 = r; v6 = v; end
    @(posedge clk);
    #1;
    model_update(0, 4, rst4, v4, int'(cmd4), int'(key4), {8'h0, a4}, {8'h0, b4});
    model_update(1, 6, rst6, v6, int'(cmd6), int'(key6), a6, b6);
    check_all();
  endtask

  initial begin
    rst4 = 1'b1; v4 = 1'b0; cmd4 = '0; key4 = '0; a4 = '0; b4 = '0;
    rst6 = 1'b1; v6 = 1'b0; cmd6 = '0; key6 = '0; a6 = '0; b6 = '0;

    // Reset both instances
    step(2, 1, 0, 0, 0, 24'h0, 24'h0);
    chk("reset_empty4", 32'(empty4), 32'd1);

    // Shift in 1,2,3,4
    for (int d = 1; d <= 4; d++) step(0, 0, 1, 3, d, 24'h0, 24'h0);
    chk("plan_1234", 32'(res4), 32'h1234);
    chk("plan_full", 32'(full4), 32'd1);

    // Shift while full rejected, then backspace
    step(0, 0, 1, 3, 5, 24'h0, 24'h0);
    chk("plan_err_full", 32'(err4), 32'd1);
    step(0, 0, 1, 4, 0, 24'h0, 24'h0);
    chk("plan_0123", 32'(res4), 32'h0123);

    // Clear, backspace on empty, then illegal key
    step(0, 0, 1, 5, 0, 24'h0, 24'h0);
    step(0, 0, 1, 4, 0, 24'h0, 24'h0);
    step(0, 0, 1, 3, 10, 24'h0, 24'h0);
    chk("plan_err_key", 32'(err4), 32'd1);
    step(0, 0, 0, 0, 0, 24'h0, 24'h0);

    // Loads, then invalid clear ignored
    step(0, 0, 1, 1, 0, 24'h9876, 24'h0042);
    chk("plan_9876", 32'(res4), 32'h9876);
    step(0, 0, 1, 2, 0, 24'h9876, 24'h0042);
    step(0, 0, 0, 5, 0, 24'h0, 24'h0);
    chk("plan_hold_0042", 32'(res4), 32'h0042);

    // Load with illegal digits, then backspace from loaded
    step(0, 0, 1, 1, 0, 24'hFAB3, 24'h0);
    step(0, 0, 1, 4, 0, 24'h0, 24'h0);

    // Reset overrides shift mid-entry
    step(0, 0, 1, 5, 0, 24'h0, 24'h0);
    step(0, 0, 1, 3, 2, 24'h0, 24'h0);
    step(0, 0, 1, 3, 8, 24'h0, 24'h0);
    step(0, 1, 1, 3, 7, 24'h0, 24'h0);
    chk("plan_reset_cnt", 32'(cnt4), 32'd0);

    // Six-digit instance: fill, overflow, reserved code
    for (int d = 1; d <= 6; d++) step(1, 0, 1, 3, d, 24'h0, 24'h0);
    chk("plan_123456", 32'(res6), 32'h123456);
    step(1, 0, 1, 3, 7, 24'h0, 24'h0);
    step(1, 0, 1, 7, 0, 24'h0, 24'h0);
    step(1, 0, 1, 6, 0, 24'h0, 24'h0);
    step(1, 0, 0, 0, 0, 24'h0, 24'h0);

    // Randomized traffic on both instances
    for (int n = 0; n < 600; n++) begin
      int k, c, key;
      bit r, v;
      k   = int'($urandom_range(0, 2));
      r   = ($urandom_range(0, 49) == 0);
      v   = ($urandom_range(0, 4) != 0);
      c   = ($urandom_range(0, 9) < 6) ? int'($urandom_range(3, 4)) : int'($urandom_range(0, 7));
      key = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
      step(k, r, v, c, key, 24'($urandom), 24'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/digit_entry_register.md
# digit_entry_register

Parametrised multi-digit register for keypad entry, replacing the fixed four-digit, two-source register in the door security datapath. It holds `DIGITS` BCD-style digits that can be:
- loaded whole from one of two sources (stored passcode or display data), or
- built up one key at a time by shift-in, with backspace and clear.

It tracks how many digits have been entered and flags illegal operations. Its outputs feed the passcode comparator and the seven-segment display driver.

## Interface
Parameters:
- `DIGITS`, 4: number of digits held (≥2).
- `DIGIT_W`, 4: bits per digit.
- `MAX_DIGIT`, 9: largest legal digit value for shift-in.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: the command on `cmd` is executed this cycle.
- `cmd` in 3: command code; see Operation.
- `key_digit` in `DIGIT_W`: digit accepted by SHIFT_IN.
- `src_a` in `DIGITS*DIGIT_W`: source A, e.g. the stored passcode.
- `src_b` in `DIGITS*DIGIT_W`: source B, e.g. display data.
- `result` out `DIGITS*DIGIT_W`: held digits. Digit i is `result[i*DIGIT_W +: DIGIT_W]`; digit 0 is the most recently entered.
- `count` out `$clog2(DIGITS+1)`: number of valid digits, 0..`DIGITS`.
- `empty` out 1: high when `count`==0.
- `full` out 1: high when `count`==`DIGITS`.
- `err` out 1: one-cycle pulse when a command is rejected.

## Operation
Command codes:
- 0 NOP: hold all state.
- 1 LOAD_A: `result`←`src_a`; `count`←`DIGITS`.
- 2 LOAD_B: `result`←`src_b`; `count`←`DIGITS`.
- 3 SHIFT_IN: digit i←digit i-1 for i≥1; digit 0←`key_digit`; `count`+1.
- 4 BACKSPACE: digit i←digit i+1 for i<`DIGITS`-1; top digit←0; `count`-1.
- 5 CLEAR: `result`←0; `count`←0.
- 6, 7: reserved. Treated as rejected: state holds, `err` pulses.

General rules:
- When `cmd_valid`=0, all state holds regardless of `cmd`; `err`=0.

Rejections (state holds, `err`=1 in the following cycle):
- SHIFT_IN while `full`.
- SHIFT_IN with `key_digit` > `MAX_DIGIT`.
- BACKSPACE while `empty`.

Other boundary conditions:
- LOAD with a source digit > `MAX_DIGIT` is loaded unchanged. No check is made on loads.
- Digits at positions ≥ `count` are always zero after SHIFT_IN, BACKSPACE and CLEAR. After a LOAD, all digits are valid.
- Arithmetic on `count` never wraps. Rejection guarantees it stays within 0..`DIGITS`.

## Timing
- Reset: when `reset`=1 at a rising edge, `result`=0, `count`=0, `empty`=1, `full`=0 and `err`=0 after that edge. `reset` overrides any command in the same cycle, including mid-entry.
- Latency: a command sampled at edge N is visible on `result`/`count` immediately after edge N. Exactly one command executes per cycle.
- `empty` and `full` are registered. They change in the same cycle as `count` and are always consistent with it.
- `err` is registered. It is high for exactly the one cycle following the rejected command's edge. Back-to-back rejections keep it high continuously.
- No back-pressure: every valid command is consumed in one cycle.

## Structure
- A shared package `door_sec_pkg` holds:
  - the command encodings (`CMD_NOP`, `CMD_LOAD_A`, `CMD_LOAD_B`, `CMD_SHIFT_IN`, `CMD_BACKSPACE`, `CMD_CLEAR`);
  - a `DIGIT_W` default constant shared with the comparator and display driver.
- Single module. The shift network is a generate loop over `DIGITS`.
- The accept/reject decision is one combinational `cmd_ok` term feeding both the datapath enable and the `err` register. No sub-module is needed.

## Test plan
All scenarios use default parameters unless stated.
- Reset, then SHIFT_IN 1,2,3,4 on consecutive cycles → `result`=16'h1234, `count`=4, `full`=1; `err` stays 0.
- From 16'h1234 full, SHIFT_IN 5 → `err` pulses for 1 cycle, `result` stays 16'h1234; then BACKSPACE → `result`=16'h0123, `count`=3.
- After CLEAR, BACKSPACE → `err`=1 for 1 cycle, `count`=0; then SHIFT_IN 4'hA → rejected, `err`=1, `result`=0.
- LOAD_A with `src_a`=16'h9876, then LOAD_B with `src_b`=16'h0042 → `result` follows each the next cycle, `count`=4 both times; `cmd_valid`=0 with `cmd`=CLEAR → no change.
- Mid-entry after two SHIFT_INs, assert `reset` together with SHIFT_IN 7 → `result`=0, `count`=0, `empty`=1, `err`=0.
- `DIGITS`=6: six SHIFT_INs of 1..6 → `result`=24'h123456, `full`=1; seventh SHIFT_IN is rejected; reserved code 7 gives an `err` pulse with no state change.
